// File: rtl/pm_grpseq.sv
// Group/step sequencer for the P-M control path: step counting, multi-register
// group transfer with mem_req/mem_ack handshake, and I/O wait with step timeout.
module pm_grpseq #(
    parameter int LK_W = 4,
    parameter int LG_W = 3
) (
    input  logic            clk,
    input  logic            clm,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [LG_W-1:0] first,
    input  logic [LG_W-1:0] count,
    input  logic [LK_W-1:0] lk_init,
    input  logic            strob,
    input  logic            mem_ack,
    input  logic            abort,
    output logic            mem_req,
    output logic [LG_W-1:0] lg,
    output logic [LK_W-1:0] lk,
    output logic            lk_nz,
    output logic            busy,
    output logic            done,
    output logic            timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_GRP,
        S_IOW,
        S_DONE
    } state_t;

    localparam logic [LK_W-1:0] LK_ZERO = '0;
    localparam logic [LK_W-1:0] LK_ONE  = LK_W'(1);
    localparam logic [LG_W-1:0] LG_ZERO = '0;
    localparam logic [LG_W-1:0] LG_ONE  = LG_W'(1);

    state_t          state_reg;
    state_t          state_next;
    logic [LK_W-1:0] lk_reg;
    logic [LG_W-1:0] lg_reg;
    logic [LG_W-1:0] rem_reg;
    logic            timeout_reg;
    logic            mem_req_reg;
    logic            busy_reg;
    logic            done_reg;

    logic            last_strob;

    // The strobe that would take lk from 1 to 0 ends STEP and times out IOW.
    assign last_strob = strob && (lk_reg == LK_ONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    case (mode)
                        2'b00:   state_next = (lk_init == LK_ZERO) ? S_DONE : S_STEP;
                        2'b01:   state_next = S_GRP;
                        2'b10:   state_next = S_IOW;
                        default: state_next = S_DONE;
                    endcase
                end
            end
            S_STEP: begin
                if (abort)
                    state_next = S_IDLE;
                else if (last_strob)
                    state_next = S_DONE;
            end
            S_GRP: begin
                if (abort)
                    state_next = S_IDLE;
                else if (mem_ack && (rem_reg == LG_ZERO))
                    state_next = S_DONE;
            end
            S_IOW: begin
                if (abort)
                    state_next = S_IDLE;
                else if (mem_ack || last_strob)
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge clm) begin
        if (clm) begin
            state_reg   <= S_IDLE;
            lk_reg      <= LK_ZERO;
            lg_reg      <= LG_ZERO;
            rem_reg     <= LG_ZERO;
            timeout_reg <= 1'b0;
            mem_req_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            busy_reg    <= (state_next != S_IDLE);
            mem_req_reg <= (state_next == S_GRP) || (state_next == S_IOW);
            done_reg    <= (state_next == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        timeout_reg <= 1'b0;
                        if ((mode == 2'b00) || (mode == 2'b10))
                            lk_reg <= lk_init;
                        if (mode == 2'b01) begin
                            lg_reg  <= first;
                            rem_reg <= count;
                        end
                    end
                end
                S_STEP: begin
                    if (!abort && strob && (lk_reg != LK_ZERO))
                        lk_reg <= lk_reg - LK_ONE;
                end
                S_GRP: begin
                    if (!abort && mem_ack && (rem_reg != LG_ZERO)) begin
                        lg_reg  <= lg_reg + LG_ONE;
                        rem_reg <= rem_reg - LG_ONE;
                    end
                end
                S_IOW: begin
                    if (!abort) begin
                        if (strob && (lk_reg != LK_ZERO))
                            lk_reg <= lk_reg - LK_ONE;
                        // An ack in the same cycle as the final strobe still wins.
                        if (mem_ack)
                            timeout_reg <= 1'b0;
                        else if (last_strob)
                            timeout_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req = mem_req_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign timeout = timeout_reg;
    assign lk      = lk_reg;
    assign lg      = lg_reg;
    assign lk_nz   = (lk_reg != LK_ZERO);

endmodule
